// File: rtl/utils_pkg.sv
// -----------------------------------------------------------------------------
// utils_pkg
//
// Shared helpers for the dual-clock FIFO controllers.
//   GrayWordWidth     : width of the words the Gray helpers operate on
//   bin_to_gray       : binary -> reflected Gray code
//   gray_to_bin       : reflected Gray code -> binary
//   gray_full_pattern : Gray value a write pointer holds when it is exactly one
//                       lap (depth entries) ahead of the given read pointer
//
// Callers zero-extend narrower pointers to GrayWordWidth bits and truncate the
// result back to their own pointer width.
// -----------------------------------------------------------------------------
package utils_pkg;

  localparam int GrayWordWidth = 32;

  function automatic logic [GrayWordWidth-1:0] bin_to_gray(
    input logic [GrayWordWidth-1:0] bin
  );
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [GrayWordWidth-1:0] gray_to_bin(
    input logic [GrayWordWidth-1:0] gray
  );
    logic [GrayWordWidth-1:0] bin;
    bin[GrayWordWidth-1] = gray[GrayWordWidth-1];
    for (int i = GrayWordWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  // A Gray pointer one full lap ahead of another differs in its top two bits
  // only. 'width' is the pointer width (address width + 1), at least 2.
  function automatic logic [GrayWordWidth-1:0] gray_full_pattern(
    input logic [GrayWordWidth-1:0] ptr,
    input int                       width
  );
    logic [GrayWordWidth-1:0] mask;
    mask = 32'h3 << (width - 2);
    return ptr ^ mask;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// Two-flop synchronizer for a multi-bit bus whose value changes at most one bit
// at a time (e.g. a Gray-coded pointer) coming from another clock domain.
//
// Ports:
//   clk_i  : destination-domain clock
//   rst_ni : asynchronous active-low reset, both stages clear to 0
//   d_i    : asynchronous input bus
//   q_o    : synchronized output, two destination edges of latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter int Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_wr_ctrl
//
// Write-side controller of the dual-clock FIFO, entirely in the write domain.
// Accepts write requests, drives the RAM write port, publishes a registered
// Gray write pointer, synchronizes the read domain's Gray pointer and derives
// registered full / almost-full / level indications.
//
// Ports:
//   clk_i          : write-domain clock
//   rst_ni         : asynchronous active-low reset
//   wr_valid_i     : write request
//   wr_ready_o     : write can be accepted (= !full_o)
//   mem_we_o       : RAM write enable (= wr_valid_i && wr_ready_o)
//   mem_waddr_o    : RAM write address
//   wr_ptr_gray_o  : registered Gray write pointer, to the read domain
//   rd_ptr_gray_i  : Gray read pointer from the read domain (asynchronous)
//   full_o         : FIFO full, registered
//   almost_full_o  : level >= AlmostFullThr, registered
//   level_o        : conservative occupancy, registered
// -----------------------------------------------------------------------------
module fifo_wr_ctrl
  import utils_pkg::*;
#(
  parameter int AddrWidth     = 4,
  parameter int AlmostFullThr = 2**AddrWidth - 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_valid_i,
  output logic                 wr_ready_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_waddr_o,
  output logic [AddrWidth:0]   wr_ptr_gray_o,
  input  logic [AddrWidth:0]   rd_ptr_gray_i,
  output logic                 full_o,
  output logic                 almost_full_o,
  output logic [AddrWidth:0]   level_o
);

  localparam int PtrW = AddrWidth + 1;
  localparam int Depth = 2**AddrWidth;
  localparam logic [PtrW-1:0] AfThr = PtrW'(AlmostFullThr);

  // Parameter sanity, caught at elaboration.
  if (AddrWidth < 1 || PtrW > GrayWordWidth) begin : g_bad_addr_width
    $error("fifo_wr_ctrl: AddrWidth must be 1..%0d", GrayWordWidth - 1);
  end
  if (AlmostFullThr < 1 || AlmostFullThr > Depth) begin : g_bad_af_thr
    $error("fifo_wr_ctrl: AlmostFullThr must be 1..depth");
  end

  // State registers
  logic [PtrW-1:0] wr_bin_q,  wr_bin_d;
  logic [PtrW-1:0] wr_gray_q, wr_gray_d;
  logic            full_q,    full_d;
  logic            afull_q,   afull_d;
  logic [PtrW-1:0] level_q,   level_d;

  // Read-pointer view in this domain
  logic [PtrW-1:0] rd_gray_sync;
  logic [PtrW-1:0] rd_bin;
  logic [PtrW-1:0] full_gray;
  logic            accept;

  sync_2ff #(
    .Width (PtrW)
  ) u_rd_ptr_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (rd_ptr_gray_i),
    .q_o    (rd_gray_sync)
  );

  // A write presented while full is simply dropped: no enable, no pointer move.
  assign accept = wr_valid_i & ~full_q;

  always_comb begin
    wr_bin_d  = wr_bin_q;
    wr_gray_d = wr_gray_q;
    full_d    = full_q;
    afull_d   = afull_q;
    level_d   = level_q;
    rd_bin    = '0;
    full_gray = '0;

    if (accept) begin
      wr_bin_d = wr_bin_q + PtrW'(1);
    end

    wr_gray_d = PtrW'(bin_to_gray(32'(wr_bin_d)));
    rd_bin    = PtrW'(gray_to_bin(32'(rd_gray_sync)));
    full_gray = PtrW'(gray_full_pattern(32'(rd_gray_sync), PtrW));

    // Flags are computed from the post-accept pointer so they never lag a
    // write; they can only lag reads (by the synchronizer), which makes them
    // pessimistic and overflow impossible.
    full_d  = (wr_gray_d == full_gray);
    level_d = wr_bin_d - rd_bin;
    afull_d = (level_d >= AfThr);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      level_q   <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      level_q   <= level_d;
    end
  end

  // The Gray pointer crosses domains, so it leaves straight from its flop.
  assign wr_ptr_gray_o = wr_gray_q;
  assign mem_waddr_o   = wr_bin_q[AddrWidth-1:0];
  assign mem_we_o      = accept;
  assign wr_ready_o    = ~full_q;
  assign full_o        = full_q;
  assign almost_full_o = afull_q;
  assign level_o       = level_q;

endmodule

// File: doc/fifo_wr_ctrl.md
# fifo_wr_ctrl

Write-side controller for the dual-clock FIFO, running entirely in the write clock domain. It accepts write requests and drives the write port of the FIFO storage RAM. It publishes a registered Gray-coded write pointer for the read domain, synchronizes the read domain's Gray read pointer, and derives the full, almost-full and level indications. It is the direct consumer of the `utils_pkg` Gray conversion functions (`bin_to_gray`, `gray_to_bin`).

## Interface
Parameters:
- `AddrWidth`, 4: storage address width; depth = 2**`AddrWidth`; legal range 1..31
- `AlmostFullThr`, 2**`AddrWidth` - 2: `almost_full_o` asserts when level >= this value; legal range 1..depth

Ports:
- `clk_i`  in  1  write-domain clock
- `rst_ni`  in  1  asynchronous active-low reset
- `wr_valid_i`  in  1  write request
- `wr_ready_o`  out  1  write can be accepted (= !`full_o`)
- `mem_we_o`  out  1  RAM write enable (= `wr_valid_i` && `wr_ready_o`)
- `mem_waddr_o`  out  `AddrWidth`  RAM write address
- `wr_ptr_gray_o`  out  `AddrWidth`+1  registered Gray write pointer, to read domain
- `rd_ptr_gray_i`  in  `AddrWidth`+1  Gray read pointer from read domain (asynchronous)
- `full_o`  out  1  FIFO full, registered
- `almost_full_o`  out  1  level >= `AlmostFullThr`, registered
- `level_o`  out  `AddrWidth`+1  conservative occupancy, registered

## Operation
- Accept = `wr_valid_i` && !`full_o`. A write while full is dropped silently; no pointer change.
- `wr_bin_q` (`AddrWidth`+1 bits) increments by 1 per accept and wraps modulo 2**(`AddrWidth`+1). `mem_waddr_o` = `wr_bin_q`[`AddrWidth`-1:0], combinational from the register.
- `wr_ptr_gray_o` = `bin_to_gray`(next `wr_bin`), registered on the same edge as `wr_bin_q`. It is driven straight from a flop with no glue logic. Exactly one bit changes per accept.
- `rd_ptr_gray_i` passes through a 2-flop synchronizer to give `rd_gray_sync`. `rd_bin` = `gray_to_bin`(`rd_gray_sync`).
- Package functions operate on 32-bit words. Pointers are zero-extended to 32 bits and results are truncated to `AddrWidth`+1 bits.
- Full (next-state): next `wr_gray` == {~`rd_gray_sync`[MSB:MSB-1], `rd_gray_sync`[MSB-2:0]}. For `AddrWidth`=1 this is the MSB:MSB-1 inversion only.
- Level (next-state): next `wr_bin` - `rd_bin`, modulo 2**(`AddrWidth`+1). The result is never greater than depth. It is an over-estimate while read progress is still in flight through the synchronizer.
- `full_o`, `almost_full_o` and `level_o` are all registered from these next-state values.
- A simultaneous accept and read-pointer update are both folded into the same next-state computation. No priority is needed.

## Timing
- Reset values (asynchronous on `rst_ni` low): `wr_bin_q`=0, `wr_ptr_gray_o`=0, both synchronizer stages=0, `full_o`=0, `almost_full_o`=0, `level_o`=0. Consequently `wr_ready_o`=1 and `mem_waddr_o`=0.
- Accept at edge N: the RAM write occurs at edge N. Address and `wr_ptr_gray_o` advance after edge N. `full_o`, `almost_full_o` and `level_o` reflect the write after edge N (zero-cycle flag lag, so overflow is impossible).
- Read pointer change on `rd_ptr_gray_i` before edge N: it is captured at edge N, synchronized at N+1, and flags update after N+2. Deassertion of `full_o` therefore lags by 3 edges.
- Reset asserted mid-operation: all state clears immediately with no clock required. After release, the first accept may occur on the first edge. Both domains are reset together at system level.

## Structure
- `utils_pkg` supplies `bin_to_gray`, `gray_to_bin` and `GrayWordWidth`.
- Add a shared function `gray_full_pattern(ptr, width)` to `utils_pkg` for reuse by the read-side controller.
- Elaboration check: `AddrWidth`+1 <= `GrayWordWidth`.
- The synchronizer is one sub-module, `sync_2ff` (parameter `Width`; ports `clk_i`, `rst_ni`, `d_i`, `q_o`; reset value 0). It is also reused by the read side.

## Test plan
- Reset: hold `rst_ni`=0 with `wr_valid_i`=1 -> `wr_ready_o`=1, `mem_we_o`=1 combinationally, all registered outputs 0. Release -> first accept at address 0.
- Fill (`AddrWidth`=4, `rd_ptr_gray_i`=0): 16 back-to-back writes -> addresses 0..15, `full_o`=1 after the 16th edge, `level_o`=16, `wr_ptr_gray_o`=5'b11000. A 17th write gives `mem_we_o`=0 and no pointer change.
- Drain release: from full, set `rd_ptr_gray_i`=5'b00001 -> `full_o` falls exactly 3 edges later and `level_o`=15.
- Almost-full (thr 14): 13 writes -> `almost_full_o`=0. The 14th write -> `almost_full_o`=1 after that edge.
- Wrap: 32 writes with the read pointer tracking -> `wr_ptr_gray_o` returns to 0. Every step changes exactly one bit (checked by assertion).
- Mid-operation reset: after 7 writes, pulse `rst_ni` low between edges -> outputs clear asynchronously and the next write goes to address 0.
